// File: rtl/vram_arbiter_if.sv
// Command/response bus between vram_arbiter and the SDRAM memory controller.
// The arbiter drives the master side, the controller the slave side.
interface vram_arbiter_if;
    logic        mc_read;
    logic        mc_write;
    logic        mc_refresh;
    logic [20:0] mc_addr;
    logic [15:0] mc_din;
    logic [1:0]  mc_wdm;
    logic [15:0] mc_dout;
    logic        mc_busy;

    modport master (
        output mc_read, mc_write, mc_refresh,
        output mc_addr, mc_din, mc_wdm,
        input  mc_dout, mc_busy
    );

    modport slave (
        input  mc_read, mc_write, mc_refresh,
        input  mc_addr, mc_din, mc_wdm,
        output mc_dout, mc_busy
    );
endinterface

// File: rtl/vram_arbiter.sv
// Single-command scheduler in front of the VRAM SDRAM controller.
// Arbitrates VDP slot accesses, the aux host port and periodic refresh.
module vram_arbiter #(
    parameter int REFRESH_INTERVAL = 810,
    parameter int REFRESH_URGENT   = 2,
    parameter int REFRESH_MAX      = 7
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        vdp_req,
    input  logic        vdp_we,
    input  logic [16:0] vdp_addr,
    input  logic [7:0]  vdp_din,
    output logic [15:0] vdp_dout,
    output logic        vdp_ack,
    output logic        vdp_overrun,
    input  logic        aux_req,
    input  logic        aux_we,
    input  logic [20:0] aux_addr,
    input  logic [15:0] aux_din,
    input  logic [1:0]  aux_wdm,
    output logic [15:0] aux_dout,
    output logic        aux_ack,
    vram_arbiter_if.master mc,
    output logic [2:0]  refresh_pending
);
    localparam int TW = $clog2(REFRESH_INTERVAL);
    localparam logic [TW-1:0] TMR_LAST = TW'(REFRESH_INTERVAL - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT_START, S_WAIT_DONE, S_DONE
    } state_t;

    typedef enum logic [1:0] {
        W_NONE, W_REF, W_VDP, W_AUX
    } win_t;

    state_t state, state_nxt;
    win_t   win, pick;

    logic          vdp_req_q, vdp_edge;
    logic          slot_full, slot_we, slot_clr;
    logic [16:0]   slot_addr;
    logic [7:0]    slot_din;
    logic          aux_req_q;
    logic          cmd_we;
    logic [20:0]   cmd_addr;
    logic [15:0]   cmd_din;
    logic [1:0]    cmd_wdm;
    logic [1:0]    wait_cnt;
    logic [TW-1:0] ref_timer;
    logic          ref_inc, start;

    assign mc.mc_addr = cmd_addr;
    assign mc.mc_din  = cmd_din;
    assign mc.mc_wdm  = cmd_wdm;

    assign vdp_edge = vdp_req & ~vdp_req_q;
    assign ref_inc  = (ref_timer == TMR_LAST);

    always_comb begin
        pick          = W_NONE;
        state_nxt     = state;
        mc.mc_read    = 1'b0;
        mc.mc_write   = 1'b0;
        mc.mc_refresh = 1'b0;
        vdp_ack       = 1'b0;
        aux_ack       = 1'b0;

        if (refresh_pending >= 3'(REFRESH_URGENT)) pick = W_REF;
        else if (slot_full)                        pick = W_VDP;
        else if (aux_req_q)                        pick = W_AUX;
        else if (refresh_pending != 3'd0)          pick = W_REF;

        unique case (state)
            S_IDLE: begin
                if (pick != W_NONE && !mc.mc_busy) state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                mc.mc_refresh = (win == W_REF);
                mc.mc_write   = (win != W_REF) && cmd_we;
                mc.mc_read    = (win != W_REF) && !cmd_we;
                state_nxt     = S_WAIT_START;
            end
            S_WAIT_START: begin
                // a command that never raises busy is taken as complete
                if (mc.mc_busy)             state_nxt = S_WAIT_DONE;
                else if (wait_cnt == 2'd3) state_nxt = S_DONE;
            end
            S_WAIT_DONE: begin
                if (!mc.mc_busy) state_nxt = S_DONE;
            end
            S_DONE: begin
                vdp_ack   = (win == W_VDP);
                aux_ack   = (win == W_AUX);
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign slot_clr = (state == S_DONE) && (win == W_VDP);
    assign start    = (state == S_IDLE) && (state_nxt == S_ISSUE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            win      <= W_NONE;
            wait_cnt <= 2'd0;
            cmd_we   <= 1'b0;
            cmd_addr <= 21'd0;
            cmd_din  <= 16'd0;
            cmd_wdm  <= 2'b00;
        end else begin
            state    <= state_nxt;
            wait_cnt <= (state == S_WAIT_START) ? wait_cnt + 2'd1 : 2'd0;
            if (start) begin
                win <= pick;
                unique case (pick)
                    W_VDP: begin
                        cmd_we   <= slot_we;
                        cmd_addr <= {5'b0, slot_addr[15:0]};
                        cmd_din  <= {slot_din, slot_din};
                        cmd_wdm  <= slot_we ?
                            {~slot_addr[16], slot_addr[16]} : 2'b00;
                    end
                    W_AUX: begin
                        cmd_we   <= aux_we;
                        cmd_addr <= aux_addr;
                        cmd_din  <= aux_din;
                        cmd_wdm  <= aux_wdm;
                    end
                    default: cmd_we <= 1'b0;
                endcase
            end
        end
    end

    // read data is captured on entry to DONE so it is valid alongside the ack
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vdp_dout <= 16'd0;
            aux_dout <= 16'd0;
        end else if (state != S_DONE && state_nxt == S_DONE && !cmd_we) begin
            if (win == W_VDP) vdp_dout <= mc.mc_dout;
            if (win == W_AUX) aux_dout <= mc.mc_dout;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vdp_req_q   <= 1'b0;
            slot_full   <= 1'b0;
            slot_we     <= 1'b0;
            slot_addr   <= 17'd0;
            slot_din    <= 8'd0;
            vdp_overrun <= 1'b0;
            aux_req_q   <= 1'b0;
        end else begin
            vdp_req_q <= vdp_req;
            aux_req_q <= aux_req & ~aux_ack;
            if (vdp_edge) begin
                if (slot_full && !slot_clr) begin
                    vdp_overrun <= 1'b1;
                end else begin
                    slot_full <= 1'b1;
                    slot_we   <= vdp_we;
                    slot_addr <= vdp_addr;
                    slot_din  <= vdp_din;
                end
            end else if (slot_clr) begin
                slot_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ref_timer       <= '0;
            refresh_pending <= 3'd0;
        end else begin
            ref_timer <= ref_inc ? '0 : ref_timer + 1'b1;
            if (ref_inc && !mc.mc_refresh) begin
                if (refresh_pending != 3'(REFRESH_MAX))
                    refresh_pending <= refresh_pending + 3'd1;
            end else if (!ref_inc && mc.mc_refresh) begin
                refresh_pending <= refresh_pending - 3'd1;
            end
        end
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a small busy/data controller model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_vram_arbiter;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        vdp_req, vdp_we;
    logic [16:0] vdp_addr;
    logic [7:0]  vdp_din;
    logic [15:0] vdp_dout;
    logic        vdp_ack, vdp_overrun;
    logic        aux_req, aux_we;
    logic [20:0] aux_addr;
    logic [15:0] aux_din;
    logic [1:0]  aux_wdm;
    logic [15:0] aux_dout;
    logic        aux_ack;
    logic [2:0]  refresh_pending;

    vram_arbiter_if mc();

    vram_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .vdp_req(vdp_req), .vdp_we(vdp_we),
        .vdp_addr(vdp_addr), .vdp_din(vdp_din),
        .vdp_dout(vdp_dout), .vdp_ack(vdp_ack),
        .vdp_overrun(vdp_overrun),
        .aux_req(aux_req), .aux_we(aux_we),
        .aux_addr(aux_addr), .aux_din(aux_din),
        .aux_wdm(aux_wdm), .aux_dout(aux_dout),
        .aux_ack(aux_ack), .mc(mc),
        .refresh_pending(refresh_pending)
    );

    always #5 clk = ~clk;

    // controller model: busy for 'lat' cycles after each command
    int          lat = 4;
    logic        hold_busy = 1'b0;
    logic [15:0] rd_data = 16'h0;
    logic [4:0]  bcnt = 5'd0;
    int          n_rd = 0, n_wr = 0, n_rf = 0, n_vack = 0, n_aack = 0;
    logic [1:0]  cmd_log[$];
    logic [20:0] last_wr_addr = 21'd0;
    logic [15:0] last_wr_din = 16'd0;

    assign mc.mc_busy = (bcnt != 5'd0) | hold_busy;

    always @(posedge clk) begin
        if (bcnt != 5'd0) bcnt <= bcnt - 5'd1;
        if (mc.mc_read | mc.mc_write | mc.mc_refresh) bcnt <= 5'(lat);
        if (mc.mc_read) begin
            mc.mc_dout <= rd_data;
            n_rd <= n_rd + 1;
            cmd_log.push_back(2'd1);
        end
        if (mc.mc_write) begin
            n_wr <= n_wr + 1;
            last_wr_addr <= mc.mc_addr;
            last_wr_din <= mc.mc_din;
            cmd_log.push_back(2'd2);
        end
        if (mc.mc_refresh) begin
            n_rf <= n_rf + 1;
            cmd_log.push_back(2'd3);
        end
        if (vdp_ack) n_vack <= n_vack + 1;
        if (aux_ack) n_aack <= n_aack + 1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic do_reset();
        reset_n = 1'b0;
        vdp_req = 0; vdp_we = 0; vdp_addr = '0; vdp_din = '0;
        aux_req = 0; aux_we = 0; aux_addr = '0; aux_din = '0;
        aux_wdm = 2'b00; hold_busy = 1'b0; lat = 4;
        repeat (15) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // one-cycle vdp_req pulse; returns on the falling edge after the rise
    task automatic vdp_pulse(input logic we, input logic [16:0] a,
                             input logic [7:0] d);
        vdp_we = we; vdp_addr = a; vdp_din = d;
        vdp_req = 1'b1;
        @(negedge clk);
        vdp_req = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_cmp++;
        if ({vdp_dout, aux_dout, refresh_pending, vdp_overrun} !== 36'd0) begin
            n_bad++;
            $display("FAIL reset_outs: got %h %h %0d %b want 0", vdp_dout,
                     aux_dout, refresh_pending, vdp_overrun);
        end
        n_cmp++;
        if ({mc.mc_read, mc.mc_write, mc.mc_refresh, vdp_ack, aux_ack}
            !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_strobes: got %b want 0",
                     {mc.mc_read, mc.mc_write, mc.mc_refresh, vdp_ack, aux_ack});
        end
    endtask

    task automatic test_vdp_write();
        int w0;
        do_reset();
        w0 = n_wr;
        vdp_pulse(1'b1, 17'h1_0123, 8'hA5);
        n_cmp++;
        if (mc.mc_write !== 1'b0) begin
            n_bad++;
            $display("FAIL wr_early: got %b want 0", mc.mc_write);
        end
        @(negedge clk);
        n_cmp++;
        if ({mc.mc_write, mc.mc_addr, mc.mc_din, mc.mc_wdm} !==
            {1'b1, 21'h000123, 16'hA5A5, 2'b01}) begin
            n_bad++;
            $display("FAIL wr_cmd: got %b %h %h %b want 1 000123 a5a5 01",
                     mc.mc_write, mc.mc_addr, mc.mc_din, mc.mc_wdm);
        end
        for (int i = 0; i < 10 && mc.mc_busy !== 1'b1; i++) @(negedge clk);
        for (int i = 0; i < 20 && mc.mc_busy !== 1'b0; i++) @(negedge clk);
        n_cmp++;
        if ({mc.mc_busy, vdp_ack} !== 2'b00) begin
            n_bad++;
            $display("FAIL wr_busyfall: busy/ack got %b want 00",
                     {mc.mc_busy, vdp_ack});
        end
        @(negedge clk);
        n_cmp++;
        if (vdp_ack !== 1'b1) begin
            n_bad++;
            $display("FAIL wr_ack: got %b want 1", vdp_ack);
        end
        @(negedge clk);
        n_cmp++;
        if (vdp_ack !== 1'b0 || n_wr - w0 != 1) begin
            n_bad++;
            $display("FAIL wr_once: ack %b writes %0d want 0 1", vdp_ack,
                     n_wr - w0);
        end
    endtask

    task automatic test_vdp_read();
        do_reset();
        rd_data = 16'hBEEF;
        vdp_pulse(1'b0, 17'h0_0040, 8'h00);
        for (int i = 0; i < 10 && mc.mc_read !== 1'b1; i++) @(negedge clk);
        n_cmp++;
        if ({mc.mc_read, mc.mc_addr, mc.mc_wdm} !== {1'b1, 21'h40, 2'b00}) begin
            n_bad++;
            $display("FAIL rd_cmd: got %b %h %b want 1 000040 00",
                     mc.mc_read, mc.mc_addr, mc.mc_wdm);
        end
        for (int i = 0; i < 30 && vdp_ack !== 1'b1; i++) @(negedge clk);
        n_cmp++;
        if ({vdp_ack, vdp_dout} !== {1'b1, 16'hBEEF}) begin
            n_bad++;
            $display("FAIL rd_data: ack %b dout %h want 1 beef", vdp_ack,
                     vdp_dout);
        end
        rd_data = 16'h1234;
        @(negedge clk);
        vdp_pulse(1'b1, 17'h0_0041, 8'h5A);
        for (int i = 0; i < 30 && vdp_ack !== 1'b1; i++) @(negedge clk);
        n_cmp++;
        if ({vdp_ack, vdp_dout} !== {1'b1, 16'hBEEF}) begin
            n_bad++;
            $display("FAIL rd_hold: ack %b dout %h want 1 beef", vdp_ack,
                     vdp_dout);
        end
    endtask

    task automatic test_no_busy();
        do_reset();
        lat = 0;
        vdp_pulse(1'b1, 17'h0_0100, 8'h01);
        @(negedge clk);
        n_cmp++;
        if (mc.mc_write !== 1'b1) begin
            n_bad++;
            $display("FAIL nb_cmd: got %b want 1", mc.mc_write);
        end
        repeat (4) @(negedge clk);
        n_cmp++;
        if (vdp_ack !== 1'b0) begin
            n_bad++;
            $display("FAIL nb_early: got %b want 0", vdp_ack);
        end
        @(negedge clk);
        n_cmp++;
        if (vdp_ack !== 1'b1) begin
            n_bad++;
            $display("FAIL nb_ack: got %b want 1", vdp_ack);
        end
    endtask

    task automatic test_refresh();
        int l0;
        do_reset();
        hold_busy = 1'b1;
        repeat (2420) @(negedge clk);
        n_cmp++;
        if (refresh_pending !== 3'd2) begin
            n_bad++;
            $display("FAIL rf_two: got %0d want 2", refresh_pending);
        end
        repeat (12) @(negedge clk);
        n_cmp++;
        if (refresh_pending !== 3'd3) begin
            n_bad++;
            $display("FAIL rf_three: got %0d want 3", refresh_pending);
        end
        vdp_pulse(1'b1, 17'h0_0200, 8'h11);
        @(negedge clk);
        l0 = cmd_log.size();
        hold_busy = 1'b0;
        for (int i = 0; i < 10 && mc.mc_refresh !== 1'b1; i++) @(negedge clk);
        n_cmp++;
        if ({mc.mc_refresh, mc.mc_write} !== 2'b10) begin
            n_bad++;
            $display("FAIL rf_first: ref/wr got %b want 10",
                     {mc.mc_refresh, mc.mc_write});
        end
        @(negedge clk);
        n_cmp++;
        if (refresh_pending !== 3'd2) begin
            n_bad++;
            $display("FAIL rf_dec: got %0d want 2", refresh_pending);
        end
        for (int i = 0; i < 60 && vdp_ack !== 1'b1; i++) @(negedge clk);
        n_cmp++;
        if (cmd_log.size() < l0 + 3) begin
            n_bad++;
            $display("FAIL rf_order: got %0d cmds want 3", cmd_log.size() - l0);
        end else if ({cmd_log[l0], cmd_log[l0+1], cmd_log[l0+2]} !== 6'b11_11_10)
        begin
            n_bad++;
            $display("FAIL rf_order: got %b want 111110",
                     {cmd_log[l0], cmd_log[l0+1], cmd_log[l0+2]});
        end
        repeat (30) @(negedge clk);
        n_cmp++;
        if (refresh_pending !== 3'd0) begin
            n_bad++;
            $display("FAIL rf_drain: got %0d want 0", refresh_pending);
        end
    endtask

    task automatic test_overrun();
        int v0, a0;
        do_reset();
        lat = 12;
        rd_data = 16'hCAFE;
        aux_addr = 21'h1ABCD; aux_we = 1'b0; aux_req = 1'b1;
        for (int i = 0; i < 10 && mc.mc_read !== 1'b1; i++) @(negedge clk);
        n_cmp++;
        if ({mc.mc_read, mc.mc_addr, vdp_overrun} !== {1'b1, 21'h1ABCD, 1'b0})
        begin
            n_bad++;
            $display("FAIL ov_aux: got %b %h %b want 1 1abcd 0", mc.mc_read,
                     mc.mc_addr, vdp_overrun);
        end
        v0 = n_vack; a0 = n_aack;
        vdp_pulse(1'b1, 17'h0_0300, 8'h22);
        @(negedge clk);
        vdp_pulse(1'b1, 17'h0_0301, 8'h33);
        for (int i = 0; i < 40 && aux_ack !== 1'b1; i++) @(negedge clk);
        n_cmp++;
        if ({aux_ack, aux_dout, vdp_overrun} !== {1'b1, 16'hCAFE, 1'b1}) begin
            n_bad++;
            $display("FAIL ov_flag: ack %b dout %h ovr %b want 1 cafe 1",
                     aux_ack, aux_dout, vdp_overrun);
        end
        aux_req = 1'b0;
        repeat (40) @(negedge clk);
        n_cmp++;
        if (n_vack - v0 != 1 || n_aack - a0 != 1) begin
            n_bad++;
            $display("FAIL ov_acks: vdp %0d aux %0d want 1 1", n_vack - v0,
                     n_aack - a0);
        end
        n_cmp++;
        if ({last_wr_addr, last_wr_din} !== {21'h300, 16'h2222}) begin
            n_bad++;
            $display("FAIL ov_kept: got %h %h want 000300 2222", last_wr_addr,
                     last_wr_din);
        end
    endtask

    task automatic test_back_to_back();
        int l0, a0;
        do_reset();
        lat = 3;
        rd_data = 16'h7E57;
        l0 = cmd_log.size(); a0 = n_aack;
        aux_addr = 21'h00055; aux_we = 1'b0; aux_req = 1'b1;
        vdp_pulse(1'b1, 17'h0_0010, 8'h44);
        for (int i = 0; i < 60 && aux_ack !== 1'b1; i++) @(negedge clk);
        n_cmp++;
        if ({aux_ack, aux_dout} !== {1'b1, 16'h7E57}) begin
            n_bad++;
            $display("FAIL b2b_aux: ack %b dout %h want 1 7e57", aux_ack,
                     aux_dout);
        end
        aux_req = 1'b0;
        repeat (20) @(negedge clk);
        n_cmp++;
        if (cmd_log.size() != l0 + 2) begin
            n_bad++;
            $display("FAIL b2b_order: got %0d cmds want 2", cmd_log.size() - l0);
        end else if ({cmd_log[l0], cmd_log[l0+1]} !== 4'b10_01) begin
            n_bad++;
            $display("FAIL b2b_order: got %b want 1001",
                     {cmd_log[l0], cmd_log[l0+1]});
        end
        n_cmp++;
        if (n_aack - a0 != 1) begin
            n_bad++;
            $display("FAIL b2b_once: got %0d aux acks want 1", n_aack - a0);
        end
    endtask

    task automatic test_reset_midflight();
        int c0, v0;
        do_reset();
        lat = 3;
        rd_data = 16'h0F0F;
        vdp_pulse(1'b0, 17'h0_0020, 8'h00);
        for (int i = 0; i < 30 && vdp_ack !== 1'b1; i++) @(negedge clk);
        n_cmp++;
        if (vdp_dout !== 16'h0F0F) begin
            n_bad++;
            $display("FAIL mr_pre: got %h want 0f0f", vdp_dout);
        end
        lat = 10;
        @(negedge clk);
        vdp_pulse(1'b1, 17'h1_0077, 8'h99);
        for (int i = 0; i < 10 && mc.mc_write !== 1'b1; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({vdp_dout, aux_dout, mc.mc_addr, mc.mc_din, mc.mc_wdm} !== 71'd0)
        begin
            n_bad++;
            $display("FAIL mr_data: got %h %h %h %h %b want 0", vdp_dout,
                     aux_dout, mc.mc_addr, mc.mc_din, mc.mc_wdm);
        end
        n_cmp++;
        if ({vdp_ack, aux_ack, mc.mc_read, mc.mc_write, mc.mc_refresh,
             vdp_overrun, refresh_pending} !== 9'd0) begin
            n_bad++;
            $display("FAIL mr_ctl: got %b %b %b%b%b %b %0d want 0", vdp_ack,
                     aux_ack, mc.mc_read, mc.mc_write, mc.mc_refresh,
                     vdp_overrun, refresh_pending);
        end
        @(negedge clk);
        reset_n = 1'b1;
        c0 = cmd_log.size(); v0 = n_vack;
        repeat (25) @(negedge clk);
        n_cmp++;
        if (cmd_log.size() != c0 || n_vack != v0) begin
            n_bad++;
            $display("FAIL mr_quiet: cmds %0d acks %0d want 0 0",
                     cmd_log.size() - c0, n_vack - v0);
        end
    endtask

    initial begin
        test_reset();
        test_vdp_write();
        test_vdp_read();
        test_no_busy();
        test_refresh();
        test_overrun();
        test_back_to_back();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
